// File: rtl/accel_host_loader_if.sv
// accel_host_loader_if: bundles the job request, the two host streams and the
// accelerator's external load/start ports into one bus.
// master = host/bench side that drives requests and stream data; slave = loader.
interface accel_host_loader_if #(
   parameter int DATA_WIDTH            = 8,
   parameter int length                = 16,
   parameter int global_buf_addr_width = 17,
   parameter int NIT_addr_width        = 12,
   parameter int NIT_neighbor          = 32,
   parameter int NIT_point_index       = 10
);
   localparam int GB_LINE_W  = DATA_WIDTH * length;
   localparam int NIT_DATA_W = (NIT_neighbor + 1) * NIT_point_index;

   // job request
   logic                             go;
   logic [global_buf_addr_width-1:0] gb_base_addr;
   logic [global_buf_addr_width-1:0] gb_num_lines;
   logic [NIT_addr_width:0]          nit_num_entries;
   logic                             busy;
   logic                             job_done;
   // host streams
   logic                             gb_valid;
   logic                             gb_ready;
   logic [GB_LINE_W-1:0]             gb_data;
   logic                             nit_valid;
   logic                             nit_ready;
   logic [NIT_DATA_W-1:0]            nit_data;
   // accelerator external ports
   logic                             accel_done;
   logic                             start;
   logic                             LOAD_DONE;
   logic                             global_buf_write_external;
   logic [global_buf_addr_width-1:0] waddr_external;
   logic [GB_LINE_W-1:0]             GB_data_line;
   logic [NIT_addr_width-1:0]        NIT_addr_external;
   logic [NIT_DATA_W-1:0]            NIT_external_data;

   modport master (
      output go, gb_base_addr, gb_num_lines, nit_num_entries,
             gb_valid, gb_data, nit_valid, nit_data, accel_done,
      input  busy, job_done, gb_ready, nit_ready, start, LOAD_DONE,
             global_buf_write_external, waddr_external, GB_data_line,
             NIT_addr_external, NIT_external_data
   );

   modport slave (
      input  go, gb_base_addr, gb_num_lines, nit_num_entries,
             gb_valid, gb_data, nit_valid, nit_data, accel_done,
      output busy, job_done, gb_ready, nit_ready, start, LOAD_DONE,
             global_buf_write_external, waddr_external, GB_data_line,
             NIT_addr_external, NIT_external_data
   );
endinterface

// File: rtl/accel_host_loader.sv
// accel_host_loader: runs one job per go -- start pulse, GB line load, NIT entry
// load, LOAD_DONE pulse, then waits for the accelerator's done.
// Ports: clk, rstn (async active-low), bus (accel_host_loader_if.slave).
// Writes appear 1 cycle after each stream handshake; ready is a pure function of state.
module accel_host_loader #(
   parameter int DATA_WIDTH            = 8,
   parameter int length                = 16,
   parameter int global_buf_addr_width = 17,
   parameter int NIT_addr_width        = 12,
   parameter int NIT_neighbor          = 32,
   parameter int NIT_point_index       = 10
) (
   input logic                clk,
   input logic                rstn,
   accel_host_loader_if.slave bus
);
   localparam int AW   = global_buf_addr_width;
   localparam int NAW  = NIT_addr_width;
   localparam int GBW  = DATA_WIDTH * length;
   localparam int NITW = (NIT_neighbor + 1) * NIT_point_index;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] LOAD_GB   = 3'd2;
   localparam logic [2:0] LOAD_NIT  = 3'd3;
   localparam logic [2:0] SIGNAL    = 3'd4;
   localparam logic [2:0] WAIT_DONE = 3'd5;

   localparam logic [AW-1:0] GB_ONE  = 1;
   localparam logic [NAW:0]  NIT_ONE = 1;

   logic [2:0]      state, state_nxt;
   logic [AW-1:0]   base_q, lines_q, gb_cnt;
   logic [NAW:0]    entries_q, nit_cnt;
   logic            gb_hs, nit_hs, gb_last, nit_last;

   logic            gb_we_q, load_done_q, job_done_q;
   logic [AW-1:0]   waddr_q;
   logic [GBW-1:0]  line_q;
   logic [NAW-1:0]  nit_addr_q;
   logic [NITW-1:0] nit_dat_q;

   assign bus.gb_ready  = (state == LOAD_GB);
   assign bus.nit_ready = (state == LOAD_NIT);
   assign bus.start     = (state == START);
   assign bus.busy      = (state != IDLE);

   assign gb_hs    = bus.gb_valid & bus.gb_ready;
   assign nit_hs   = bus.nit_valid & bus.nit_ready;
   assign gb_last  = gb_hs & ((gb_cnt + GB_ONE) == lines_q);
   assign nit_last = nit_hs & ((nit_cnt + NIT_ONE) == entries_q);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (bus.go) state_nxt = START;
         START: begin
            if (lines_q != '0)        state_nxt = LOAD_GB;
            else if (entries_q != '0) state_nxt = LOAD_NIT;
            else                      state_nxt = SIGNAL;
         end
         LOAD_GB:   if (gb_last) state_nxt = (entries_q != '0) ? LOAD_NIT : SIGNAL;
         LOAD_NIT:  if (nit_last) state_nxt = SIGNAL;
         SIGNAL:    state_nxt = WAIT_DONE;
         WAIT_DONE: if (bus.accel_done) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         base_q      <= '0;
         lines_q     <= '0;
         entries_q   <= '0;
         gb_cnt      <= '0;
         nit_cnt     <= '0;
         gb_we_q     <= 1'b0;
         waddr_q     <= '0;
         line_q      <= '0;
         nit_addr_q  <= '0;
         nit_dat_q   <= '0;
         load_done_q <= 1'b0;
         job_done_q  <= 1'b0;
      end else begin
         state <= state_nxt;

         // config is captured only on an accepted go, so it is frozen for the job
         if (state == IDLE && bus.go) begin
            base_q    <= bus.gb_base_addr;
            lines_q   <= bus.gb_num_lines;
            entries_q <= bus.nit_num_entries;
            gb_cnt    <= '0;
            nit_cnt   <= '0;
         end

         gb_we_q <= gb_hs;
         if (gb_hs) begin
            waddr_q <= base_q + gb_cnt;   // wraps modulo 2^AW by width
            line_q  <= bus.gb_data;
            gb_cnt  <= gb_cnt + GB_ONE;
         end

         // NIT write enable belongs to the accelerator; only address/data are driven
         if (nit_hs) begin
            nit_addr_q <= nit_cnt[NAW-1:0];
            nit_dat_q  <= bus.nit_data;
            nit_cnt    <= nit_cnt + NIT_ONE;
         end

         // registered so LOAD_DONE lands strictly after the final write is presented
         load_done_q <= (state == SIGNAL);
         job_done_q  <= (state == WAIT_DONE) && bus.accel_done;
      end
   end

   assign bus.global_buf_write_external = gb_we_q;
   assign bus.waddr_external            = waddr_q;
   assign bus.GB_data_line              = line_q;
   assign bus.NIT_addr_external         = nit_addr_q;
   assign bus.NIT_external_data         = nit_dat_q;
   assign bus.LOAD_DONE                 = load_done_q;
   assign bus.job_done                  = job_done_q;
endmodule

// File: tb/tb_accel_host_loader.sv
module tb_accel_host_loader;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   accel_host_loader_if bus ();

   accel_host_loader dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // expected held values of the registered write buses
   logic [16:0]  exp_wa;
   logic [127:0] exp_line;
   logic [11:0]  exp_na;
   logic [329:0] exp_nd;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [329:0] rnd_nit();
      logic [351:0] t;
      for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
      return t[329:0];
   endfunction

   task automatic clear_model();
      exp_wa = '0; exp_line = '0; exp_na = '0; exp_nd = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {bus.start, bus.LOAD_DONE, bus.global_buf_write_external, bus.waddr_external,
                bus.GB_data_line, bus.NIT_addr_external, bus.NIT_external_data,
                bus.busy, bus.job_done, bus.gb_ready, bus.nit_ready}, '0);
   endtask

   // One job. Called at a negedge. Cycle c counts from the cycle in which go is driven (c=0).
   // mode: 0 streams always valid, 1 random valid, 2 GB valid pattern 1,0,0,1,1 from c=2.
   task automatic run_job(input logic [16:0] base, input logic [16:0] lines,
                          input logic [12:0] entries, input int mode, input bit early);
      logic [127:0] gbq[$];
      logic [329:0] nitq[$];
      logic [4:0]   pat;
      int gi, ni, nw, nn, c, exp_ld, exp_jd, dly;
      bit pg, pn, gh, nh;
      pat = 5'b11001;
      for (int k = 0; k < int'(lines) + 2; k++) gbq.push_back({$urandom, $urandom, $urandom, $urandom});
      for (int k = 0; k < int'(entries) + 2; k++) nitq.push_back(rnd_nit());
      gi = 0; ni = 0; nw = 0; nn = 0; c = 0; pg = 0; pn = 0;
      dly = $urandom_range(1, 2);
      exp_ld = 1000000; exp_jd = 1000000;
      if (lines == 0 && entries == 0) begin
         exp_ld = 3;
         exp_jd = exp_ld + (early ? 0 : dly) + 1;
      end
      bus.go = 1'b1; bus.gb_base_addr = base; bus.gb_num_lines = lines; bus.nit_num_entries = entries;
      bus.gb_valid = 1'b0; bus.nit_valid = 1'b0; bus.accel_done = early;
      while (c < exp_jd + 3 && c < 600) begin
         @(posedge clk); #1; c++;
         bus.go = (c == 3);   // second go while busy must be ignored
         bus.gb_base_addr = 17'($urandom); bus.gb_num_lines = 17'($urandom);
         bus.nit_num_entries = 13'($urandom);
         if (mode == 0)      bus.gb_valid = 1'b1;
         else if (mode == 2) bus.gb_valid = (c >= 2) ? pat[(c - 2) % 5] : 1'b0;
         else                bus.gb_valid = 1'($urandom_range(0, 1));
         bus.gb_data   = gbq[gi];
         bus.nit_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.nit_data  = nitq[ni];
         bus.accel_done = early ? 1'b1 : (c == exp_ld + dly);
         @(negedge clk);
         // reference: writes appear the cycle after each accepted beat, in order
         if (pg) begin exp_wa = base + 17'(nw); exp_line = gbq[nw]; nw++; end
         if (pn) begin exp_na = 12'(nn); exp_nd = nitq[nn]; nn++; end
         if ((pg || pn) && nw == int'(lines) && nn == int'(entries)) begin
            exp_ld = c + 1;
            exp_jd = exp_ld + (early ? 0 : dly) + 1;
         end
         chk("start", bus.start, c == 1);
         chk("gb_strobe", bus.global_buf_write_external, pg);
         chk("gb_bus", {bus.waddr_external, bus.GB_data_line}, {exp_wa, exp_line});
         chk("nit_bus", {bus.NIT_addr_external, bus.NIT_external_data}, {exp_na, exp_nd});
         chk("load_done", bus.LOAD_DONE, c == exp_ld);
         chk("job_done", bus.job_done, c == exp_jd);
         chk("busy", bus.busy, c < exp_jd);
         chk("rdy_excl", bus.gb_ready & bus.nit_ready, 1'b0);
         gh = bus.gb_valid & bus.gb_ready;
         nh = bus.nit_valid & bus.nit_ready;
         if (gh) gi++;
         if (nh) ni++;
         pg = gh; pn = nh;
      end
      chk("job_finished", c < 600, 1'b1);
      chk("gb_writes", nw, lines);
      chk("nit_writes", nn, entries);
      bus.accel_done = 1'b0; bus.gb_valid = 1'b0; bus.nit_valid = 1'b0; bus.go = 1'b0;
   endtask

   task automatic reset_mid_nit();
      int c;
      bus.go = 1'b1; bus.gb_base_addr = 17'h00100; bus.gb_num_lines = 17'd1;
      bus.nit_num_entries = 13'd20; bus.gb_valid = 1'b1; bus.nit_valid = 1'b1;
      bus.gb_data = '1; bus.nit_data = '1;
      c = 0;
      while (c < 20) begin
         @(posedge clk); #1; c++;
         bus.go = 1'b0;
         @(negedge clk);
         if (bus.nit_ready) break;
      end
      chk("reached_load_nit", bus.nit_ready, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      #2 rstn = 1'b0;
      #1 chk_all_zero("abort_outputs");
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      clear_model();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_quiet", {bus.start, bus.LOAD_DONE, bus.job_done, bus.busy,
                             bus.gb_ready, bus.nit_ready}, '0);
      end
      bus.gb_valid = 1'b0; bus.nit_valid = 1'b0;
   endtask

   initial begin
      bus.go = 1'b0; bus.gb_base_addr = '0; bus.gb_num_lines = '0; bus.nit_num_entries = '0;
      bus.gb_valid = 1'b1; bus.gb_data = '1; bus.nit_valid = 1'b1; bus.nit_data = '1;
      bus.accel_done = 1'b0;
      clear_model();
      #1 chk_all_zero("reset_outputs");
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle_after_reset", {bus.busy, bus.start, bus.gb_ready, bus.nit_ready}, '0);
      end
      bus.gb_valid = 1'b0; bus.nit_valid = 1'b0;

      run_job(17'h1FFFE, 17'd4, 13'd2, 0, 1'b0);        // address wrap, back-to-back beats
      run_job(17'($urandom), 17'd3, 13'd2, 2, 1'b0);    // GB host stalls 1,0,0,1,1
      run_job(17'($urandom), 17'd0, 13'd0, 0, 1'b0);    // empty job
      run_job(17'($urandom), 17'd3, 13'd2, 1, 1'b1);    // accel_done held from the start
      run_job(17'($urandom), 17'd2, 13'd0, 0, 1'b0);    // GB only
      run_job(17'($urandom), 17'd0, 13'd3, 1, 1'b0);    // NIT only
      for (int j = 0; j < 8; j++)
         run_job(17'($urandom), 17'($urandom_range(0, 6)), 13'($urandom_range(0, 5)),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));

      reset_mid_nit();
      run_job(17'h1FFFF, 17'd3, 13'd3, 0, 1'b0);        // fresh job after abort

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
